window_3x3_gen: RTL and testbench
=================================

Name: window_3x3_gen

Overview:
- Upstream neighbour of the convolution stage. Turns a raster-order grayscale pixel stream into 3x3 neighbourhood windows, packed as 72 bits.
- Each window feeds the convolution stage's 72-bit grayscale window input, one window per interior pixel.
- Uses two line buffers plus a 3x3 shift register. Valid/ready handshakes on both sides.

Parameters:
- COLDepth, 8, bits per pixel.
- Image_width, 512, pixels per row; must be >= 3.
- Image_height, 512, rows per frame; must be >= 3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_in  in  COLDepth  grayscale pixel, raster order (row 0 col 0 first).
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  block accepts a pixel this cycle.
- window_out  out  9*COLDepth  packed 3x3 window.
- window_valid  out  1  window_out is valid.
- window_ready  in  1  downstream accepts the window.
- window_last  out  1  qualifies window_valid; marks the final window of the frame.
- frame_done  out  1  one-cycle pulse when the last window of the frame is accepted.

Behaviour:
- Reset values: pixel_ready=1, window_out=0, window_valid=0, window_last=0, frame_done=0; row/col counters 0.
  - Line buffer contents are not cleared. They are masked by the row/col start-up rules.
- Accept condition: a pixel is accepted when pixel_valid && pixel_ready.
  - pixel_ready = !window_valid || window_ready, a single output register with a combinational ready path.
- Counters:
  - col increments on each accepted pixel; at Image_width-1 it wraps to 0 and row increments.
  - At row=Image_height-1 and col=Image_width-1, both wrap to 0 and the next frame begins.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each Image_width x COLDepth.
  - On an accepted pixel at column c: read lb0[c] and lb1[c], write lb1[c]<=lb0[c] and lb0[c]<=pixel_in.
  - The 3-tall column {lb1[c], lb0[c], pixel_in} shifts into the 3x3 register.
- Window emission:
  - A pixel accepted at (row>=2, col>=2) registers a window on the next clock with window_valid=1. Latency is 1 cycle.
  - The window spans rows r-2..r and cols c-2..c, centred at (r-1, c-1).
  - No windows are emitted for row<2 or col<2 (no padding). Each frame yields exactly (Image_height-2)*(Image_width-2) windows.
- Packing is row-major, top-left at MSB: window_out[71:64]=P(r-2,c-2) ... window_out[7:0]=P(r,c).
  - Index k of the convolution kernel matrices maps to byte 8-k.
- window_last=1 with the window produced by pixel (Image_height-1, Image_width-1).
- frame_done pulses in the cycle after window_valid && window_ready && window_last.
- Hold rule: while window_valid && !window_ready, window_out and window_last are stable and no pixel is accepted.
- Accepting a pixel that emits no window, while the held window is consumed in the same cycle, clears window_valid next cycle.
- Simultaneous consume and emit in one cycle: the new window loads and window_valid stays 1.
- Reset mid-frame: immediate return to reset values. The next accepted pixel is treated as (0,0).
- Back-to-back frames need no idle cycles. Row 0 of the new frame never emits, so stale buffer data is never exposed.

Optional Feature:
- Macro WINDOW_COORD_EN.
- When defined, adds outputs win_x [15:0] and win_y [15:0], the centre coordinates (c-1, r-1).
  - They are registered and held with window_out, and reset to 0.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package edge_pkg holds:
  - COLDepth;
  - typedef pixel_t = logic [COLDepth-1:0];
  - typedef window_t = logic [9*COLDepth-1:0];
  - function pack_window(pixel_t p[9]) returning window_t per the packing rule above.
- The convolution stage imports the same package.
- One sub-module, line_buffer: a single-port-per-cycle read-then-write array, depth Image_width, with a combinational read. Instantiated twice.

Test Plan:
- Image_width=5, Image_height=4, pixel = row*16+col streamed with no stalls:
  - first window is 72'h000102101112202122, one cycle after pixel (2,2) is accepted;
  - exactly 6 windows are produced;
  - window_last is set on the window centred at (2,3);
  - frame_done pulses once.
- Same image with window_ready low for 3 cycles while a window is pending:
  - window_out is held stable and pixel_ready=0 throughout;
  - the window sequence is identical to the no-stall run.
- Random pixel_valid gaps (50%) with random window_ready: the window stream matches a reference model byte-for-byte.
- Assert reset after 9 pixels of a frame, then restart the stream: no window_valid before pixel (2,2) of the new frame; output matches a clean frame.
- Two back-to-back frames with different data:
  - the second frame's first window contains only second-frame pixels;
  - frame_done pulses twice.
- With WINDOW_COORD_EN defined, 5x4 image: coordinates go (1,1), (2,1), (3,1), (1,2), (2,2), (3,2) in step with the windows.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared pixel/window types and window packing for the edge pipeline
// (window generator and convolution stage).
package edge_pkg;

  localparam int unsigned COLDepth = 8;

  typedef logic [COLDepth-1:0]   pixel_t;
  typedef logic [9*COLDepth-1:0] window_t;

  // Row-major 3x3 packing: p[0] (top-left) lands in the most significant byte.
  function automatic window_t pack_window(input pixel_t p[9]);
    window_t w;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      w[(8-k)*COLDepth +: COLDepth] = p[k];
    end
    return w;
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out handshake bundle for window_3x3_gen.
// WINDOW_COORD_EN adds the win_x/win_y centre-coordinate outputs.
interface window_3x3_gen_if;
  import edge_pkg::*;

  pixel_t  pixel_in;
  logic    pixel_valid;
  logic    pixel_ready;
  window_t window_out;
  logic    window_valid;
  logic    window_ready;
  logic    window_last;
  logic    frame_done;
`ifdef WINDOW_COORD_EN
  logic [15:0] win_x;
  logic [15:0] win_y;

  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window_out, window_valid, window_last, frame_done,
    output win_x, win_y
  );
  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window_out, window_valid, window_last, frame_done,
    input  win_x, win_y
  );
`else
  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window_out, window_valid, window_last, frame_done
  );
  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window_out, window_valid, window_last, frame_done
  );
`endif

endinterface

// File: rtl/line_buffer.sv
// One image row of pixel storage: combinational read, write at the same
// address on the clock edge (read-then-write within a cycle).
module line_buffer
  import edge_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  pixel_t                   wdata_i,
  output pixel_t                   rdata_o
);

  pixel_t mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream to 3x3 neighbourhood windows (one per interior pixel).
// Optional WINDOW_COORD_EN: registered window centre coordinates win_x/win_y.
module window_3x3_gen
  import edge_pkg::*;
#(
  parameter int unsigned Image_width  = 512,
  parameter int unsigned Image_height = 512
) (
  input  logic              clk,
  input  logic              reset,
  window_3x3_gen_if.slave   bus
);

  localparam int unsigned COL_W = $clog2(Image_width);
  localparam int unsigned ROW_W = $clog2(Image_height);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pixel_t           c1_q [3];
  pixel_t           c1_d [3];
  pixel_t           c2_q [3];
  pixel_t           c2_d [3];
  window_t          window_q, window_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
`ifdef WINDOW_COORD_EN
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
`endif

  pixel_t lb0_rd;
  pixel_t lb1_rd;
  pixel_t win_pix [9];
  logic   pixel_ready_c;
  logic   accept;
  logic   emit;
  logic   consumed;
  logic   at_last_col;
  logic   at_last_row;

  assign pixel_ready_c = !valid_q || bus.window_ready;
  assign accept        = bus.pixel_valid && pixel_ready_c;
  assign consumed      = valid_q && bus.window_ready;
  assign at_last_col   = (col_q == COL_W'(Image_width - 1));
  assign at_last_row   = (row_q == ROW_W'(Image_height - 1));
  assign emit          = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value.
  line_buffer #(.DEPTH(Image_width)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (bus.pixel_in),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(Image_width)) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Window = two stored columns (c-2, c-1) plus the incoming column c.
  always_comb begin
    win_pix[0] = c2_q[0];
    win_pix[1] = c1_q[0];
    win_pix[2] = lb1_rd;
    win_pix[3] = c2_q[1];
    win_pix[4] = c1_q[1];
    win_pix[5] = lb0_rd;
    win_pix[6] = c2_q[2];
    win_pix[7] = c1_q[2];
    win_pix[8] = bus.pixel_in;
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    window_d = window_q;
    valid_d  = valid_q && !bus.window_ready;
    last_d   = consumed ? 1'b0 : last_q;
    done_d   = consumed && last_q;
`ifdef WINDOW_COORD_EN
    x_d      = x_q;
    y_d      = y_q;
`endif

    if (accept) begin
      c2_d = c1_q;
      c1_d = '{lb1_rd, lb0_rd, bus.pixel_in};
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (emit) begin
      window_d = pack_window(win_pix);
      valid_d  = 1'b1;
      last_d   = at_last_row && at_last_col;
`ifdef WINDOW_COORD_EN
      x_d      = 16'(col_q) - 16'd1;
      y_d      = 16'(row_q) - 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      c1_q     <= '{default: '0};
      c2_q     <= '{default: '0};
      window_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef WINDOW_COORD_EN
      x_q      <= '0;
      y_q      <= '0;
`endif
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
`ifdef WINDOW_COORD_EN
      x_q      <= x_d;
      y_q      <= y_d;
`endif
    end
  end

  assign bus.pixel_ready  = pixel_ready_c;
  assign bus.window_out   = window_q;
  assign bus.window_valid = valid_q;
  assign bus.window_last  = last_q;
  assign bus.frame_done   = done_q;
`ifdef WINDOW_COORD_EN
  assign bus.win_x        = x_q;
  assign bus.win_y        = y_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// Scoreboard bench for window_3x3_gen on a 5x4 image: driver pushes expected
// windows on pixel acceptance, monitor pops and compares on window handshakes.
module tb_window_3x3_gen;
  import edge_pkg::*;

  localparam int unsigned W = 5;
  localparam int unsigned H = 4;

  typedef struct packed {
    logic [71:0] win;
    logic        last;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_3x3_gen_if bus ();

  window_3x3_gen #(.Image_width(W), .Image_height(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        exp_q [$];
  logic [71:0] win_log [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          win_count = 0;
  int          fd_count = 0;
  int          ready_mode = 0;
  logic        stall_done = 1'b0;
  logic        expect_fd = 1'b0;
  logic        first_seen = 1'b0;
  logic [71:0] first_win = '0;
  logic [71:0] last_win = '0;
  logic [15:0] last_x = '0;
  logic [15:0] last_y = '0;
  int          first_win_cyc = 0;
  int          accept22_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pixel_ready"},  128'(bus.pixel_ready), 128'(1));
    chk({tag, "_window_valid"}, 128'(bus.window_valid), 128'(0));
    chk({tag, "_window_out"},   128'(bus.window_out), 128'(0));
    chk({tag, "_window_last"},  128'(bus.window_last), 128'(0));
    chk({tag, "_frame_done"},   128'(bus.frame_done), 128'(0));
  endtask

  task automatic clear_stats();
    win_count  = 0;
    fd_count   = 0;
    first_seen = 1'b0;
    win_log.delete();
  endtask

  // Drive one frame (or its first npix pixels); called and returns at posedge+1.
  task automatic send_frame(input logic [7:0] base, input bit rnd, input bit gaps, input int npix);
    logic [7:0]  img [H][W];
    logic [71:0] w;
    exp_t        e;
    bit          acc;
    int          sent;
    for (int r = 0; r < int'(H); r++)
      for (int c = 0; c < int'(W); c++)
        img[r][c] = rnd ? 8'($urandom) : base + 8'(r * 16 + c);
    sent = 0;
    for (int r = 0; r < int'(H); r++) begin
      for (int c = 0; c < int'(W); c++) begin
        if (sent < npix) begin
          bus.pixel_in = img[r][c];
          acc = 1'b0;
          while (!acc) begin
            bus.pixel_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            @(negedge clk);
            acc = bus.pixel_valid && bus.pixel_ready;
            if (acc && r >= 2 && c >= 2) begin
              w = '0;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  w[71 - 8*(3*i + j) -: 8] = img[r-2+i][c-2+j];
              e.win  = w;
              e.last = (r == int'(H) - 1) && (c == int'(W) - 1);
              e.x    = 16'(c - 1);
              e.y    = 16'(r - 1);
              exp_q.push_back(e);
              if (r == 2 && c == 2) accept22_cyc = cyc;
            end
            @(posedge clk);
            #1;
          end
          sent++;
        end
      end
    end
    bus.pixel_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus.window_valid) && i < 500) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    expect_fd = 1'b0;
  endtask

  // Downstream ready: 0 = always ready, 1 = random, 2 = one 3-cycle stall on the first window.
  initial begin : ready_proc
    logic [71:0] held;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: bus.window_ready = 1'($urandom_range(1, 0));
        2: begin
          bus.window_ready = 1'b1;
          if (!stall_done && bus.window_valid) begin
            held = bus.window_out;
            bus.window_ready = 1'b0;
            repeat (3) begin
              @(negedge clk);
              chk("stall_valid", 128'(bus.window_valid), 128'(1));
              chk("stall_hold", 128'(bus.window_out), 128'(held));
              chk("stall_pixel_ready", 128'(bus.pixel_ready), 128'(0));
              @(posedge clk);
              #1;
            end
            bus.window_ready = 1'b1;
            stall_done = 1'b1;
          end
        end
        default: bus.window_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.frame_done || expect_fd) begin
        chk("frame_done", 128'(bus.frame_done), 128'(expect_fd));
      end
      if (bus.frame_done) fd_count++;
      expect_fd = 1'b0;
      if (bus.window_valid && !first_seen) begin
        first_seen    = 1'b1;
        first_win     = bus.window_out;
        first_win_cyc = cyc;
      end
      if (bus.window_valid && exp_q.size() == 0) begin
        chk("spurious_window", 128'(bus.window_out), 128'(0));
        if (bus.window_out == '0) begin
          n_fail++;
          $display("FAIL spurious_window: got valid zero window, expected none");
        end
      end else if (bus.window_valid && bus.window_ready) begin
        e = exp_q.pop_front();
        chk("window_out", 128'(bus.window_out), 128'(e.win));
        chk("window_last", 128'(bus.window_last), 128'(e.last));
`ifdef WINDOW_COORD_EN
        chk("win_x", 128'(bus.win_x), 128'(e.x));
        chk("win_y", 128'(bus.win_y), 128'(e.y));
`endif
        win_count++;
        win_log.push_back(bus.window_out);
        if (bus.window_last) begin
          last_win  = bus.window_out;
`ifdef WINDOW_COORD_EN
          last_x    = bus.win_x;
          last_y    = bus.win_y;
`endif
          expect_fd = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset            = 1'b1;
    bus.pixel_valid  = 1'b0;
    bus.pixel_in     = '0;
    bus.window_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // No-stall reference frame
    clear_stats();
    send_frame(8'h00, 1'b0, 1'b0, W * H);
    drain();
    chk("t1_count", 128'(win_count), 128'(6));
    chk("t1_frame_done", 128'(fd_count), 128'(1));
    chk("t1_first_win", 128'(first_win), 128'(72'h000102101112202122));
    chk("t1_latency", 128'(first_win_cyc - accept22_cyc), 128'(1));
    chk("t1_last_win", 128'(last_win), 128'(72'h121314222324323334));
`ifdef WINDOW_COORD_EN
    chk("t1_last_xy", 128'({last_x, last_y}), 128'({16'd3, 16'd2}));
`endif

    // Stall on the first window
    ready_mode = 2;
    stall_done = 1'b0;
    clear_stats();
    send_frame(8'h00, 1'b0, 1'b0, W * H);
    drain();
    chk("t2_stalled", 128'(stall_done), 128'(1));
    chk("t2_count", 128'(win_count), 128'(6));
    chk("t2_frame_done", 128'(fd_count), 128'(1));
    chk("t2_first_win", 128'(first_win), 128'(72'h000102101112202122));
    chk("t2_last_win", 128'(last_win), 128'(72'h121314222324323334));

    // Random data, input gaps and random downstream ready
    ready_mode = 1;
    clear_stats();
    send_frame(8'h00, 1'b1, 1'b1, W * H);
    send_frame(8'h00, 1'b1, 1'b1, W * H);
    drain();
    chk("t3_count", 128'(win_count), 128'(12));
    chk("t3_frame_done", 128'(fd_count), 128'(2));

    // Reset after 9 pixels, then a clean frame
    ready_mode = 0;
    #0 bus.window_ready = 1'b1;
    send_frame(8'h00, 1'b0, 1'b0, 9);
    pulse_reset();
    clear_stats();
    send_frame(8'h00, 1'b0, 1'b0, W * H);
    drain();
    chk("t4_count", 128'(win_count), 128'(6));
    chk("t4_first_win", 128'(first_win), 128'(72'h000102101112202122));
    chk("t4_frame_done", 128'(fd_count), 128'(1));

    // Back-to-back frames with different data
    clear_stats();
    send_frame(8'h40, 1'b0, 1'b0, W * H);
    send_frame(8'h80, 1'b0, 1'b0, W * H);
    drain();
    chk("t5_count", 128'(win_count), 128'(12));
    chk("t5_frame_done", 128'(fd_count), 128'(2));
    chk("t5_f1_first", 128'(win_log.size() > 0 ? win_log[0] : 72'h0), 128'(72'h404142505152606162));
    chk("t5_f2_first", 128'(win_log.size() > 6 ? win_log[6] : 72'h0), 128'(72'h808182909192a0a1a2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
